// File: rtl/branch_resolve_if.sv
// branch_resolve_if
//   Request / comparator / response bundle for the branch resolution unit.
//   master : requester side (issues requests, provides the comparator result,
//            consumes responses)
//   slave  : branch_resolve side
//   Request  : req_valid, req_ready, req_kind, req_funct3, req_pc, rs1_val,
//              b_imm, j_imm, i_imm
//   Compare  : cmpop (funct3 to comparator), cmpmux_sel (0 = rs2_out), br_en
//   Response : resp_valid, resp_ready, resp_taken, resp_target, resp_link,
//              resp_misaligned, resp_illegal
interface branch_resolve_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_funct3;
  logic [31:0] req_pc;
  logic [31:0] rs1_val;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic [31:0] i_imm;

  logic [2:0]  cmpop;
  logic        cmpmux_sel;
  logic        br_en;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_taken;
  logic [31:0] resp_target;
  logic [31:0] resp_link;
  logic        resp_misaligned;
  logic        resp_illegal;

  modport master (
    output req_valid, req_kind, req_funct3, req_pc, rs1_val, b_imm, j_imm, i_imm,
    input  req_ready,
    input  cmpop, cmpmux_sel,
    output br_en,
    input  resp_valid, resp_taken, resp_target, resp_link, resp_misaligned, resp_illegal,
    output resp_ready
  );

  modport slave (
    input  req_valid, req_kind, req_funct3, req_pc, rs1_val, b_imm, j_imm, i_imm,
    output req_ready,
    output cmpop, cmpmux_sel,
    input  br_en,
    output resp_valid, resp_taken, resp_target, resp_link, resp_misaligned, resp_illegal,
    input  resp_ready
  );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve
//   Resolves one branch / jal / jalr request at a time through an
//   IDLE -> EVAL -> RESP sequence, then commits the target to the PC register
//   and counts taken redirects on the response handshake.
//   clk         : sole clock, rising edge
//   rst         : asynchronous, active-high reset
//   bus         : branch_resolve_if.slave (request, comparator, response)
//   pc_out      : committed PC register (RESET_PC after reset)
//   taken_count : committed taken redirects, wraps at 16 bits
module branch_resolve #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolve_if.slave  bus,
  output logic [31:0]      pc_out,
  output logic [15:0]      taken_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_RESP
  } state_t;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JAL    = 2'b01;
  localparam logic [1:0] KIND_JALR   = 2'b10;
  localparam logic [2:0] F3_BEQ      = 3'b000;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_kind;
  logic [2:0]  r_funct3;
  logic [31:0] r_req_pc;
  logic [31:0] r_rs1;
  logic [31:0] r_bimm;
  logic [31:0] r_jimm;
  logic [31:0] r_iimm;

  logic        r_taken;
  logic [31:0] r_target;
  logic [31:0] r_link;
  logic        r_mis;
  logic        r_ill;

  logic [31:0] r_pc;
  logic [15:0] r_cnt;

  logic        w_req_ready;
  logic        w_resp_valid;
  logic [2:0]  w_cmpop;
  logic        w_accept;
  logic        w_resp_hs;

  logic        w_taken;
  logic [31:0] w_target;
  logic [31:0] w_link;
  logic        w_mis;
  logic        w_ill;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_cmpop      = F3_BEQ;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_next = S_EVAL;
      end
      S_EVAL: begin
        w_cmpop = r_funct3;
        w_next  = S_RESP;
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept  = bus.req_valid && w_req_ready;
  assign w_resp_hs = w_resp_valid && bus.resp_ready;

  // ---------------- request capture ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kind   <= '0;
      r_funct3 <= '0;
      r_req_pc <= '0;
      r_rs1    <= '0;
      r_bimm   <= '0;
      r_jimm   <= '0;
      r_iimm   <= '0;
    end else if (w_accept) begin
      r_kind   <= bus.req_kind;
      r_funct3 <= bus.req_funct3;
      r_req_pc <= bus.req_pc;
      r_rs1    <= bus.rs1_val;
      r_bimm   <= bus.b_imm;
      r_jimm   <= bus.j_imm;
      r_iimm   <= bus.i_imm;
    end
  end

  // ---------------- resolution (valid during EVAL) ----------------
  always_comb begin
    w_link   = r_req_pc + 32'd4;
    w_taken  = 1'b0;
    w_target = w_link;
    w_ill    = 1'b0;
    case (r_kind)
      KIND_BRANCH: begin
        if (r_funct3 == 3'b010 || r_funct3 == 3'b011) begin
          w_ill = 1'b1;
        end else if (bus.br_en) begin
          w_taken  = 1'b1;
          w_target = r_req_pc + r_bimm;
        end
      end
      KIND_JAL: begin
        w_taken  = 1'b1;
        w_target = r_req_pc + r_jimm;
      end
      KIND_JALR: begin
        w_taken  = 1'b1;
        w_target = (r_rs1 + r_iimm) & ~32'h1;
      end
      default: w_ill = 1'b1;
    endcase
    w_mis = w_taken && (w_target[1:0] != 2'b00);
  end

  // Result registers load on the EVAL->RESP edge, which is also where br_en
  // is sampled; they then hold until the next evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken  <= 1'b0;
      r_target <= '0;
      r_link   <= '0;
      r_mis    <= 1'b0;
      r_ill    <= 1'b0;
    end else if (r_state == S_EVAL) begin
      r_taken  <= w_taken;
      r_target <= w_target;
      r_link   <= w_link;
      r_mis    <= w_mis;
      r_ill    <= w_ill;
    end
  end

  // ---------------- commit ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= RESET_PC;
      r_cnt <= '0;
    end else if (w_resp_hs && !r_mis && !r_ill) begin
      r_pc <= r_target;
      if (r_taken) r_cnt <= r_cnt + 16'd1;
    end
  end

  // ---------------- outputs ----------------
  assign bus.req_ready       = w_req_ready;
  assign bus.resp_valid      = w_resp_valid;
  assign bus.cmpop           = w_cmpop;
  assign bus.cmpmux_sel      = 1'b0;  // rs2_out
  assign bus.resp_taken      = r_taken;
  assign bus.resp_target     = r_target;
  assign bus.resp_link       = r_link;
  assign bus.resp_misaligned = r_mis;
  assign bus.resp_illegal    = r_ill;
  assign pc_out              = r_pc;
  assign taken_count         = r_cnt;

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0060, value loaded into pc_out at reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  branch/jump request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_kind  input  2  2'b00 branch, 2'b01 jal, 2'b10 jalr, 2'b11 reserved.
REQ-007 SHALL have port req_funct3  input  3  branch_funct3_t condition for branches.
REQ-008 SHALL have ports req_pc, rs1_val, b_imm, j_imm, i_imm  input  32 each  instruction PC, rs1 value, sign-extended immediates.
REQ-009 SHALL have port cmpop  output  3  branch_funct3_t driven to the comparator.
REQ-010 SHALL have port cmpmux_sel  output  cmpmux_sel_t  comparator operand select; always rs2_out.
REQ-011 SHALL have port br_en  input  1  comparator result, combinational from cmpop.
REQ-012 SHALL have port resp_valid  output  1  resolution result available.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-014 SHALL have ports resp_taken 1, resp_target 32, resp_link 32, resp_misaligned 1, resp_illegal 1  outputs  resolution result fields.
REQ-015 SHALL have port pc_out  output  32  committed PC register.
REQ-016 SHALL have port taken_count  output  16  count of committed taken redirects.

Function
REQ-017 SHALL implement FSM states IDLE, EVAL, RESP; IDLE->EVAL on req_valid&&req_ready; EVAL->RESP unconditionally; RESP->IDLE on resp_valid&&resp_ready; RESP holds otherwise.
REQ-018 SHALL assert req_ready only in IDLE and resp_valid only in RESP.
REQ-019 SHALL capture req_kind, req_funct3, req_pc, rs1_val and all immediates on the accepting edge; later input changes SHALL NOT affect the result.
REQ-020 SHALL drive cmpop from captured funct3 during EVAL and sample br_en on the EVAL->RESP edge; outside EVAL cmpop SHALL be beq.
REQ-021 SHALL give latency: request accepted edge N, resp_valid high from cycle N+2.
REQ-022 SHALL hold all resp_* fields stable while resp_valid is high and not yet accepted.
REQ-023 Branch: resp_taken = sampled br_en; target = pc+b_imm if taken else pc+4.
REQ-024 jal: resp_taken=1, target = pc+j_imm, br_en ignored.
REQ-025 jalr: resp_taken=1, target = (rs1_val+i_imm) & ~32'h1, br_en ignored.
REQ-026 SHALL compute resp_link = pc+4 for all kinds; all adds modulo 2^32 (wrap, no flag).
REQ-027 resp_illegal SHALL be 1 for req_kind 2'b11 or branch funct3 3'b010/3'b011; then resp_taken=0, target=pc+4.
REQ-028 resp_misaligned SHALL be 1 iff resp_taken and target[1:0]!=2'b00 (after jalr bit-0 clear).
REQ-029 On response handshake pc_out SHALL load resp_target, unless resp_misaligned or resp_illegal, in which case pc_out is unchanged.
REQ-030 On response handshake with resp_taken=1 and not misaligned/illegal, taken_count SHALL increment, wrapping 16'hFFFF->16'h0000.
REQ-031 Response handshake and new request SHALL NOT overlap: a request is accepted no earlier than the cycle after RESP->IDLE.

Reset
REQ-032 On rst assertion, independent of clk, SHALL go to IDLE, pc_out=RESET_PC, taken_count=0, resp_valid=0, all resp_* fields=0, cmpop=beq.
REQ-033 Reset mid-EVAL or mid-RESP SHALL discard the in-flight request with no pc_out or taken_count update.
REQ-034 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-035 beq taken: pc=0x100, b_imm=0x20, br_en=1 in EVAL -> resp_valid at N+2, taken=1, target=0x120, link=0x104; pc_out=0x120, taken_count=1 after handshake.
REQ-036 bne not taken with resp_ready low 3 cycles: pc=0x200, br_en=0 -> target=0x204, fields stable 3 cycles; pc_out=0x204, taken_count unchanged.
REQ-037 jalr: rs1=0x1003, i_imm=0x4 -> target=0x1006 (bit 0 cleared), misaligned=1, pc_out unchanged, taken_count unchanged.
REQ-038 funct3=3'b010 -> illegal=1, taken=0, target=pc+4, pc_out unchanged; jal pc=0xFFFF_FFF0, j_imm=0x20 -> target=0x0000_0010.
REQ-039 taken_count preset to 0xFFFF via 65535 taken branches, one more -> 0x0000.
REQ-040 rst pulsed asynchronously during RESP -> resp_valid=0 immediately, pc_out=0x60, req_ready=1 first cycle after release.
